// File: rtl/gc_wptr.sv
// rtl/gc_wptr.sv - async FIFO write pointer: binary count, registered Grey publish, full/level
module gc_wptr #(
  parameter int ADDR_W    = 4,
  parameter int AF_THRESH = 12
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              push,
  input  logic [ADDR_W:0]   rd_gc_sync,
  output logic              accept,
  output logic [ADDR_W-1:0] waddr,
  output logic [ADDR_W:0]   wptr_gc,
  output logic              full,
  output logic              almost_full,
  output logic [ADDR_W:0]   level
);

  localparam int PW = ADDR_W + 1;

  // Full is "Grey write pointer equals read pointer with its top two bits
  // inverted"; the mask covers ADDR_W=1, where both bits are the top two.
  localparam logic [ADDR_W:0] FULL_MASK = PW'(3) << (ADDR_W - 1);

  // Threshold widened by one bit so AF_THRESH = 2^ADDR_W+... stays exact.
  localparam logic [ADDR_W+1:0] AF_LIMIT = (ADDR_W + 2)'(AF_THRESH);

  logic [ADDR_W:0] wbin;
  logic [ADDR_W:0] wbin_next;
  logic [ADDR_W:0] gnext;
  logic [ADDR_W:0] rbin;
  logic [ADDR_W:0] diff;

  // A push is taken only when the registered full flag is clear.
  assign accept    = push & ~full;
  assign waddr     = wbin[ADDR_W-1:0];
  assign wbin_next = wbin + {{ADDR_W{1'b0}}, accept};
  assign gnext     = wbin_next ^ (wbin_next >> 1);
  assign diff      = wbin_next - rbin;

  // Grey-to-binary decode of the synchronized read pointer, MSB downward.
  always_comb begin
    rbin = '0;
    rbin[ADDR_W] = rd_gc_sync[ADDR_W];
    for (int i = ADDR_W - 1; i >= 0; i--) begin
      rbin[i] = rbin[i+1] ^ rd_gc_sync[i];
    end
  end

  // Pointer and status registers; every output crossing domains is a flop.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wbin        <= '0;
      wptr_gc     <= '0;
      full        <= 1'b0;
      almost_full <= 1'b0;
      level       <= '0;
    end else begin
      wbin        <= wbin_next;
      wptr_gc     <= gnext;
      full        <= (gnext == (rd_gc_sync ^ FULL_MASK));
      almost_full <= ({1'b0, diff} >= AF_LIMIT);
      level       <= diff;
    end
  end

endmodule

// File: tb/tb_gc_wptr.sv
// tb/tb_gc_wptr.sv - self-checking bench for gc_wptr against a count-based FIFO model
module tb_gc_wptr;

  logic       clk;
  logic       rst;
  logic       push;
  logic [4:0] rd_gc_sync;
  logic       accept;
  logic [3:0] waddr;
  logic [4:0] wptr_gc;
  logic       full;
  logic       almost_full;
  logic [4:0] level;

  int errors = 0;
  int checks = 0;

  // Reference model: total writes and reads as unbounded counts.
  int  mw;        // writes accepted so far
  int  mr_drive;  // read count currently presented on rd_gc_sync
  int  mr_seen;   // read count sampled at the last clock edge
  bit  m_full;    // occupancy at last edge was 16

  gc_wptr #(.ADDR_W(4), .AF_THRESH(12)) dut (
    .clk(clk), .rst(rst), .push(push), .rd_gc_sync(rd_gc_sync),
    .accept(accept), .waddr(waddr), .wptr_gc(wptr_gc), .full(full),
    .almost_full(almost_full), .level(level)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [4:0] to_grey(input int n);
    logic [4:0] b;
    b = 5'(n % 32);
    return b ^ (b >> 1);
  endfunction

  function automatic int occ();
    return mw - mr_seen;
  endfunction

  task automatic model_clear();
    mw = 0; mr_drive = 0; mr_seen = 0; m_full = 0;
  endtask

  // Present inputs for the coming edge, then let combinational logic settle.
  task automatic drive(input bit p, input int r);
    push = p;
    mr_drive = r;
    rd_gc_sync = to_grey(r);
    #1;
  endtask

  // Advance one clock and apply the FIFO rules to the model.
  task automatic tick();
    @(posedge clk);
    if (push && !m_full) mw++;
    mr_seen = mr_drive;
    m_full = (occ() == 16);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1; push = 1'b0; rd_gc_sync = '0;
    model_clear();
    #3;
    checks++; if (wptr_gc !== 5'd0 || full !== 1'b0 || almost_full !== 1'b0 || level !== 5'd0 || waddr !== 4'd0) begin
      errors++; $display("FAIL reset_state: gc=%b full=%b af=%b level=%0d waddr=%0d, want all 0", wptr_gc, full, almost_full, level, waddr);
    end
    @(posedge clk); @(posedge clk); #1;
    rst = 1'b0;
    #1;
  endtask

  task automatic test_fill();
    logic [4:0] first4 [4];
    first4[0] = 5'b00001; first4[1] = 5'b00011; first4[2] = 5'b00010; first4[3] = 5'b00110;
    for (int i = 1; i <= 16; i++) begin
      drive(1'b1, 0);
      checks++; if (accept !== 1'b1) begin errors++; $display("FAIL fill_accept[%0d]: got %b want 1", i, accept); end
      tick();
      checks++; if (wptr_gc !== to_grey(mw)) begin errors++; $display("FAIL fill_gc[%0d]: got %b want %b", i, wptr_gc, to_grey(mw)); end
      if (i <= 4) begin
        checks++; if (wptr_gc !== first4[i-1]) begin errors++; $display("FAIL fill_gc_table[%0d]: got %b want %b", i, wptr_gc, first4[i-1]); end
      end
      checks++; if (almost_full !== (i >= 12)) begin errors++; $display("FAIL fill_af[%0d]: got %b want %b", i, almost_full, i >= 12); end
      checks++; if (full !== (i == 16)) begin errors++; $display("FAIL fill_full[%0d]: got %b want %b", i, full, i == 16); end
      checks++; if (level !== 5'(i)) begin errors++; $display("FAIL fill_level[%0d]: got %0d want %0d", i, level, i); end
    end
    checks++; if (wptr_gc !== 5'b11000) begin errors++; $display("FAIL fill_final_gc: got %b want 11000", wptr_gc); end
  endtask

  task automatic test_full_hold();
    for (int i = 0; i < 4; i++) begin
      drive(1'b1, 0);
      checks++; if (accept !== 1'b0) begin errors++; $display("FAIL hold_accept[%0d]: got %b want 0", i, accept); end
      tick();
      checks++; if (wptr_gc !== 5'b11000 || waddr !== 4'd0 || level !== 5'd16 || full !== 1'b1) begin
        errors++; $display("FAIL hold_state[%0d]: gc=%b waddr=%0d level=%0d full=%b want 11000/0/16/1", i, wptr_gc, waddr, level, full);
      end
    end
  endtask

  task automatic test_read_release();
    drive(1'b0, 5);
    checks++; if (rd_gc_sync !== 5'b00111) begin errors++; $display("FAIL release_grey: got %b want 00111", rd_gc_sync); end
    tick();
    checks++; if (full !== 1'b0 || level !== 5'd11 || almost_full !== 1'b0) begin
      errors++; $display("FAIL release_state: full=%b level=%0d af=%b want 0/11/0", full, level, almost_full);
    end
    drive(1'b1, 5);
    checks++; if (accept !== 1'b1 || waddr !== 4'd0) begin
      errors++; $display("FAIL release_push: accept=%b waddr=%0d want 1/0", accept, waddr);
    end
    tick();
    checks++; if (level !== 5'(occ()) || level !== 5'd12) begin errors++; $display("FAIL release_level: got %0d want 12", level); end
  endtask

  task automatic test_wrap();
    logic [4:0] prev;
    bit saw_wrap;
    rst = 1'b1; #2; rst = 1'b0;
    model_clear();
    push = 1'b0; rd_gc_sync = '0;
    #1;
    for (int i = 0; i < 3; i++) begin drive(1'b1, 0); tick(); end
    checks++; if (level !== 5'd3) begin errors++; $display("FAIL wrap_prefill: got %0d want 3", level); end
    saw_wrap = 0;
    prev = wptr_gc;
    for (int i = 0; i < 40; i++) begin
      drive(1'b1, mw - 2);
      tick();
      checks++; if (level !== 5'd3 || full !== 1'b0 || wptr_gc !== to_grey(mw)) begin
        errors++; $display("FAIL wrap_step[%0d]: level=%0d full=%b gc=%b want 3/0/%b", i, level, full, wptr_gc, to_grey(mw));
      end
      if (prev == 5'b10000 && wptr_gc == 5'b00000) saw_wrap = 1;
      prev = wptr_gc;
    end
    checks++; if (saw_wrap !== 1'b1) begin errors++; $display("FAIL wrap_seen: got %b want 1 (10000->00000)", saw_wrap); end
  endtask

  task automatic test_random();
    logic [4:0] prev;
    int k;
    prev = wptr_gc;
    for (int c = 0; c < 10000; c++) begin
      k = $urandom_range(0, 3);
      if (k == 3) k = 0;
      if (mr_drive + k > mw) k = mw - mr_drive;
      drive(($urandom_range(0, 9) < 6), mr_drive + k);
      checks++; if (accept !== (push && !m_full)) begin
        errors++; $display("FAIL rand_accept[%0d]: got %b want %b", c, accept, push && !m_full);
      end
      tick();
      checks++; if ($countones(wptr_gc ^ prev) > 1) begin
        errors++; $display("FAIL rand_grey_step[%0d]: %b -> %b changes %0d bits", c, prev, wptr_gc, $countones(wptr_gc ^ prev));
      end
      checks++; if (level !== 5'(occ()) || full !== (occ() == 16) || almost_full !== (occ() >= 12) || wptr_gc !== to_grey(mw)) begin
        errors++; $display("FAIL rand_state[%0d]: level=%0d full=%b af=%b gc=%b want %0d/%b/%b/%b", c, level, full, almost_full, wptr_gc, occ(), occ() == 16, occ() >= 12, to_grey(mw));
      end
      checks++; if (occ() > 16) begin errors++; $display("FAIL rand_overflow[%0d]: occupancy %0d want <=16", c, occ()); end
      prev = wptr_gc;
    end
  endtask

  task automatic test_async_reset();
    for (int i = 0; i < 5; i++) begin drive(1'b1, mr_drive); tick(); end
    drive(1'b1, mr_drive);
    #2;
    rst = 1'b1;
    #1;
    checks++; if (wptr_gc !== 5'd0 || full !== 1'b0 || almost_full !== 1'b0 || level !== 5'd0 || waddr !== 4'd0) begin
      errors++; $display("FAIL async_reset: gc=%b full=%b af=%b level=%0d waddr=%0d want all 0", wptr_gc, full, almost_full, level, waddr);
    end
    push = 1'b0; rd_gc_sync = '0;
    @(posedge clk); #3;
    rst = 1'b0;
    model_clear();
    #1;
    drive(1'b1, 0);
    tick();
    checks++; if (wptr_gc !== 5'b00001 || level !== 5'd1) begin
      errors++; $display("FAIL post_reset_push: gc=%b level=%0d want 00001/1", wptr_gc, level);
    end
  endtask

  initial begin
    test_reset();
    test_fill();
    test_full_hold();
    test_read_release();
    test_wrap();
    test_random();
    test_async_reset();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
